// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer driving the program counter's reset/update controls,
// fetch strobes, halt handling, fetch timeout and retired-instruction count.
module pc_sequencer #(
  parameter int unsigned WORD_SIZE     = 8,
  parameter int unsigned MEM_ADDR_SIZE = 8,
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned RETIRE_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    reset_enable_n,
  input  logic                    start,
  input  logic                    halt_request,
  input  logic                    mem_ready,
  input  logic                    execute_done,
  input  logic                    branch_taken,
  input  logic                    halt_instr,
  input  logic [WORD_SIZE-1:0]    branch_offset,
  input  logic                    stall,
  output logic                    pc_reset_enable,
  output logic                    pc_update_enable,
  output logic [WORD_SIZE-1:0]    pc_value,
  output logic                    fetch_request,
  output logic                    instr_valid,
  output logic                    halted,
  output logic                    fetch_error,
  output logic [RETIRE_WIDTH-1:0] retired_count,
  output logic [2:0]              state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    FETCH    = 3'd2,
    WAIT_MEM = 3'd3,
    EXECUTE  = 3'd4,
    UPDATE   = 3'd5,
    HALTED   = 3'd6
  } state_e;

  if (WORD_SIZE < MEM_ADDR_SIZE || FETCH_TIMEOUT < 1 || FETCH_TIMEOUT > 255) begin : g_param_check
    $error("pc_sequencer: invalid parameter combination");
  end

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [WORD_SIZE-1:0]    offset_q, offset_d;
  logic [7:0]              tmo_q, tmo_d;
  logic                    halt_pending_q, halt_pending_d;
  logic                    fetch_error_q, fetch_error_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;

  always_ff @(posedge clock or negedge reset_enable_n) begin
    if (!reset_enable_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_enable_n) begin
    if (!reset_enable_n) begin
      offset_q       <= '0;
      tmo_q          <= '0;
      halt_pending_q <= 1'b0;
      fetch_error_q  <= 1'b0;
      instr_valid_q  <= 1'b0;
      retired_q      <= '0;
    end else begin
      offset_q       <= offset_d;
      tmo_q          <= tmo_d;
      halt_pending_q <= halt_pending_d;
      fetch_error_q  <= fetch_error_d;
      instr_valid_q  <= instr_valid_d;
      retired_q      <= retired_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    offset_d       = offset_q;
    tmo_d          = tmo_q;
    halt_pending_d = halt_pending_q;
    fetch_error_d  = fetch_error_q;
    instr_valid_d  = 1'b0;
    retired_d      = retired_q;

    if (halt_request && state_q != IDLE && state_q != HALTED) begin
      halt_pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE, HALTED: begin
        // Session counters clear on entry so they already read zero in CLEAR.
        if (start) begin
          state_d        = CLEAR;
          retired_d      = '0;
          fetch_error_d  = 1'b0;
          halt_pending_d = 1'b0;
        end
      end
      CLEAR: state_d = FETCH;
      FETCH: begin
        tmo_d   = '0;
        state_d = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_ready) begin
          state_d       = EXECUTE;
          instr_valid_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d       = HALTED;
          fetch_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      EXECUTE: begin
        if (execute_done) begin
          if (halt_instr) begin
            state_d = HALTED;
          end else begin
            offset_d = branch_taken ? branch_offset : WORD_SIZE'(1);
            state_d  = UPDATE;
          end
        end
      end
      UPDATE: begin
        if (!stall) begin
          if (retired_q != '1) begin
            retired_d = retired_q + RETIRE_WIDTH'(1);
          end
          state_d = (halt_pending_q || halt_request) ? HALTED : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_reset_enable  = (state_q == CLEAR);
    fetch_request    = (state_q == FETCH);
    pc_update_enable = (state_q == UPDATE) && !stall;
    halted           = (state_q == HALTED);
    pc_value         = offset_q;
    instr_valid      = instr_valid_q;
    fetch_error      = fetch_error_q;
    retired_count    = retired_q;
    state            = state_q;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations plus a
// random phase, all checked every cycle against a behavioural model.
module tb_pc_sequencer;

  localparam int FT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt_request = 1'b0, mem_ready = 1'b0, execute_done = 1'b0;
  logic        branch_taken = 1'b0, halt_instr = 1'b0, stall = 1'b0;
  logic [7:0]  branch_offset = '0;
  logic        pc_reset_enable, pc_update_enable, fetch_request, instr_valid;
  logic        halted, fetch_error;
  logic [7:0]  pc_value;
  logic [15:0] retired_count;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;

  // Model: phase number equals the observable state code.
  int         m_phase = 0, m_wait = 0, m_ret = 0, m_pc = 0;
  logic [7:0] m_off = '0;
  bit         m_hp = 0, m_err = 0, m_ivld = 0;
  int         dut_pc = 0;

  localparam logic [6:0] S = 7'd1, HR = 7'd2, MR = 7'd4, ED = 7'd8, BT = 7'd16, HI = 7'd32, ST = 7'd64;

  pc_sequencer #(.WORD_SIZE(8), .MEM_ADDR_SIZE(8), .FETCH_TIMEOUT(FT), .RETIRE_WIDTH(16)) dut (
    .clock(clk), .reset_enable_n(rst_n), .start(start), .halt_request(halt_request),
    .mem_ready(mem_ready), .execute_done(execute_done), .branch_taken(branch_taken),
    .halt_instr(halt_instr), .branch_offset(branch_offset), .stall(stall),
    .pc_reset_enable(pc_reset_enable), .pc_update_enable(pc_update_enable),
    .pc_value(pc_value), .fetch_request(fetch_request), .instr_valid(instr_valid),
    .halted(halted), .fetch_error(fetch_error), .retired_count(retired_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wait = 0; m_ret = 0; m_off = '0;
    m_hp = 0; m_err = 0; m_ivld = 0;
  endtask

  task automatic model_step();
    int ph = m_phase;
    if (ph == 1) m_pc = 0;
    if (ph == 5 && !stall) m_pc = (m_pc + int'(m_off)) % 256;
    m_ivld = 0;
    if (halt_request && ph >= 1 && ph <= 5) m_hp = 1;
    if (ph == 0 || ph == 6) begin
      if (start) begin m_phase = 1; m_ret = 0; m_err = 0; m_hp = 0; end
    end else if (ph == 1) begin
      m_phase = 2;
    end else if (ph == 2) begin
      m_phase = 3; m_wait = 0;
    end else if (ph == 3) begin
      m_wait++;
      if (mem_ready) begin m_phase = 4; m_ivld = 1; end
      else if (m_wait == FT) begin m_phase = 6; m_err = 1; end
    end else if (ph == 4) begin
      if (execute_done) begin
        if (halt_instr) m_phase = 6;
        else begin m_off = branch_taken ? branch_offset : 8'd1; m_phase = 5; end
      end
    end else if (ph == 5) begin
      if (!stall) begin
        if (m_ret < 65535) m_ret++;
        m_phase = m_hp ? 6 : 2;
      end
    end
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_phase);
    chk("pc_reset_enable", int'(pc_reset_enable), int'(m_phase == 1));
    chk("fetch_request", int'(fetch_request), int'(m_phase == 2));
    chk("pc_update_enable", int'(pc_update_enable), int'(m_phase == 5 && !stall));
    chk("pc_value", int'(pc_value), int'(m_off));
    chk("instr_valid", int'(instr_valid), int'(m_ivld));
    chk("halted", int'(halted), int'(m_phase == 6));
    chk("fetch_error", int'(fetch_error), int'(m_err));
    chk("retired_count", int'(retired_count), m_ret);
  endtask

  // Single compare process: emulate program_counter, advance model, check.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (pc_reset_enable) dut_pc = 0;
        else if (pc_update_enable) dut_pc = (dut_pc + int'(pc_value)) % 256;
        model_step();
      end
      #1 compare_all();
    end
  end

  task automatic drv(input logic [6:0] f, input logic [7:0] off);
    start = f[0]; halt_request = f[1]; mem_ready = f[2]; execute_done = f[3];
    branch_taken = f[4]; halt_instr = f[5]; stall = f[6]; branch_offset = off;
    @(negedge clk);
  endtask

  // Entered in FETCH; leaves in FETCH after a zero-wait instruction.
  task automatic run_instr(input logic [6:0] f, input logic [7:0] off, input int exp_pv);
    drv(7'd0, 8'd0);
    drv(MR, 8'd0);
    chk("d_instr_valid", int'(instr_valid), 1);
    drv(ED | f, off);
    chk("d_update_pulse", int'(pc_update_enable), 1);
    chk("d_pc_value", int'(pc_value), exp_pv);
    drv(7'd0, 8'd0);
    chk("d_back_to_fetch", int'(state), 2);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("d_reset_state", int'(state), 0);
    chk("d_reset_retired", int'(retired_count), 0);
    rst_n = 1'b1;
    drv(7'd0, 8'd0);
    chk("d_idle_hold", int'(state), 0);
    drv(S, 8'd0);
    chk("d_clear_state", int'(state), 1);
    chk("d_pc_reset_hi", int'(pc_reset_enable), 1);
    drv(7'd0, 8'd0);
    chk("d_fetch_state", int'(state), 2);
    chk("d_pc_reset_lo", int'(pc_reset_enable), 0);
    chk("d_fetch_req", int'(fetch_request), 1);

    for (int i = 0; i < 3; i++) run_instr(7'd0, 8'd0, 1);
    chk("d_pc_after3", dut_pc, 3);
    chk("d_model_pc_after3", m_pc, 3);
    chk("d_retired3", int'(retired_count), 3);

    run_instr(7'd0, 8'd0, 1);
    run_instr(7'd0, 8'd0, 1);
    run_instr(BT, 8'hFD, 253);
    chk("d_pc_backbranch", dut_pc, 2);
    run_instr(BT, 8'd3, 3);
    run_instr(BT, 8'd0, 0);
    chk("d_pc_selfloop", dut_pc, 5);
    chk("d_retired_selfloop", int'(retired_count), 8);

    drv(7'd0, 8'd0);
    drv(MR, 8'd0);
    drv(ED | ST, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk("d_stall_state", int'(state), 5);
      chk("d_stall_no_pulse", int'(pc_update_enable), 0);
      if (i < 2) drv(ST, 8'd0);
    end
    stall = 1'b0;
    #1 chk("d_stall_release_pulse", int'(pc_update_enable), 1);
    @(negedge clk);
    chk("d_after_stall_fetch", int'(state), 2);
    chk("d_after_stall_retired", int'(retired_count), 9);
    chk("d_after_stall_pc", dut_pc, 6);

    drv(7'd0, 8'd0);
    repeat (FT - 1) drv(7'd0, 8'd0);
    chk("d_tmo_still_wait", int'(state), 3);
    chk("d_tmo_no_err_yet", int'(fetch_error), 0);
    drv(7'd0, 8'd0);
    chk("d_tmo_halted", int'(state), 6);
    chk("d_tmo_error", int'(fetch_error), 1);

    drv(S, 8'd0);
    chk("d_restart_clear", int'(state), 1);
    chk("d_restart_err_clr", int'(fetch_error), 0);
    chk("d_restart_ret_clr", int'(retired_count), 0);
    drv(7'd0, 8'd0);
    drv(7'd0, 8'd0);
    repeat (FT - 1) drv(7'd0, 8'd0);
    drv(MR, 8'd0);
    chk("d_last_cycle_ready", int'(state), 4);
    chk("d_last_cycle_noerr", int'(fetch_error), 0);

    drv(ED, 8'd0);
    drv(7'd0, 8'd0);
    drv(7'd0, 8'd0);
    drv(HR, 8'd0);
    chk("d_hr_still_wait", int'(state), 3);
    drv(MR, 8'd0);
    drv(ED, 8'd0);
    chk("d_hr_update_pulse", int'(pc_update_enable), 1);
    drv(7'd0, 8'd0);
    chk("d_hr_halted", int'(state), 6);
    chk("d_hr_pc", dut_pc, 2);
    chk("d_hr_retired", int'(retired_count), 2);

    drv(S, 8'd0);
    drv(7'd0, 8'd0);
    drv(7'd0, 8'd0);
    drv(MR, 8'd0);
    drv(ED | HI, 8'd0);
    chk("d_hinstr_halted", int'(state), 6);
    chk("d_hinstr_retired", int'(retired_count), 0);
    chk("d_hinstr_pc", dut_pc, 0);

    drv(S, 8'd0);
    drv(7'd0, 8'd0);
    drv(7'd0, 8'd0);
    drv(MR, 8'd0);
    drv(ED | BT, 8'd7);
    drv(7'd0, 8'd0);
    drv(7'd0, 8'd0);
    drv(MR, 8'd0);
    chk("d_pre_async_exec", int'(state), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("d_async_state", int'(state), 0);
    chk("d_async_pc_value", int'(pc_value), 0);
    chk("d_async_retired", int'(retired_count), 0);
    chk("d_async_valid", int'(instr_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(7'd0, 8'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [6:0] f;
      f[0] = ($urandom_range(0, 5) == 0);
      f[1] = ($urandom_range(0, 15) == 0);
      f[2] = ($urandom_range(0, 2) != 0);
      f[3] = $urandom_range(0, 1) == 1;
      f[4] = $urandom_range(0, 1) == 1;
      f[5] = ($urandom_range(0, 9) == 0);
      f[6] = ($urandom_range(0, 3) == 0);
      drv(f, 8'($urandom_range(0, 255)));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
